bus_arbiter: RTL and testbench

Two-master arbiter and address decoder for the 12-bit memory-mapped console bus. It sits between the CPU-side requester (m0) and a vblank DMA/update requester (m1) on one side, and the text buffer (0x4xx) and sprite register file (0x5xx) on the other. It serialises accesses into fixed 3-cycle transactions. Round-robin is the normal policy; m1 gets fixed priority for a programmable window after each vsync rising edge.

---
 rtl/bus_arbiter_if.sv | 41 ++++
 rtl/bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_bus_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Console bus bundle between the two requesters, the arbiter and the two slaves.
interface bus_arbiter_if;
    logic        vsync;
    logic        m0_req;
    logic        m1_req;
    logic [11:0] m0_addr;
    logic [11:0] m1_addr;
    logic        m0_we;
    logic        m1_we;
    logic [7:0]  m0_wdata;
    logic [7:0]  m1_wdata;
    logic        m0_ack;
    logic        m1_ack;
    logic [7:0]  m0_rdata;
    logic [7:0]  m1_rdata;
    logic [11:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        tb_we;
    logic        tb_oe;
    logic        spr_we;
    logic        spr_oe;
    logic [7:0]  tb_rdata;
    logic [7:0]  spr_rdata;
    logic        busy;

    // Arbiter side
    modport slave (
        input  vsync, m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we,
               m0_wdata, m1_wdata, tb_rdata, spr_rdata,
        output m0_ack, m1_ack, m0_rdata, m1_rdata, bus_addr, bus_wdata,
               tb_we, tb_oe, spr_we, spr_oe, busy
    );

    // Requester / slave environment side
    modport master (
        output vsync, m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we,
               m0_wdata, m1_wdata, tb_rdata, spr_rdata,
        input  m0_ack, m1_ack, m0_rdata, m1_rdata, bus_addr, bus_wdata,
               tb_we, tb_oe, spr_we, spr_oe, busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master arbiter and page decoder for the 12-bit console bus.
// Fixed 3-cycle transactions; round-robin with an m1-priority window after vsync.
module bus_arbiter #(
    parameter int unsigned VBLANK_CYCLES = 256,
    parameter logic [3:0]  TB_PAGE       = 4'h4,
    parameter logic [3:0]  SPR_PAGE      = 4'h5
) (
    input  logic           clk,
    input  logic           reset,
    bus_arbiter_if.slave   bus
);
    localparam int unsigned VB_W = 16;
    localparam int unsigned AW   = 12;
    localparam int unsigned DW   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    logic [VB_W-1:0] vb_cnt;
    logic            vsync_q;
    logic            last_grant;
    logic            owner;
    logic            we_q;
    logic            sel_tb;
    logic            sel_spr;
    logic [DW-1:0]   hold0;
    logic [DW-1:0]   hold1;

    logic            req_any_c;
    logic            win_c;
    logic [AW-1:0]   win_addr_c;
    logic            win_we_c;
    logic [DW-1:0]   win_wdata_c;
    logic            win_tb_c;
    logic            win_spr_c;
    logic [DW-1:0]   resp_data_c;

    // Winner selection from the current requests and window state
    always_comb begin
        req_any_c = bus.m0_req | bus.m1_req;
        if ((vb_cnt != '0) && bus.m1_req) begin
            win_c = 1'b1;
        end else if (bus.m0_req && !bus.m1_req) begin
            win_c = 1'b0;
        end else if (bus.m1_req && !bus.m0_req) begin
            win_c = 1'b1;
        end else begin
            win_c = ~last_grant;
        end
        win_addr_c  = win_c ? bus.m1_addr  : bus.m0_addr;
        win_we_c    = win_c ? bus.m1_we    : bus.m0_we;
        win_wdata_c = win_c ? bus.m1_wdata : bus.m0_wdata;
        win_tb_c    = (win_addr_c[11:8] == TB_PAGE);
        win_spr_c   = (win_addr_c[11:8] == SPR_PAGE);
    end

    // Completion data: writes return 0, unmapped reads return all ones
    always_comb begin
        if (we_q) begin
            resp_data_c = 8'h00;
        end else if (sel_tb) begin
            resp_data_c = bus.tb_rdata;
        end else if (sel_spr) begin
            resp_data_c = bus.spr_rdata;
        end else begin
            resp_data_c = 8'hFF;
        end
    end

    // Slave read data arrives in RESP, so the owner sees it directly then and the held copy afterwards
    assign bus.m0_rdata = ((state == RESP) && !owner) ? resp_data_c : hold0;
    assign bus.m1_rdata = ((state == RESP) &&  owner) ? resp_data_c : hold1;

    // Vblank priority window: loads on each vsync rising edge, counts down to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q <= 1'b1;
            vb_cnt  <= '0;
        end else begin
            vsync_q <= bus.vsync;
            if (bus.vsync && !vsync_q) begin
                vb_cnt <= VB_W'(VBLANK_CYCLES);
            end else if (vb_cnt != '0) begin
                vb_cnt <= vb_cnt - VB_W'(1);
            end
        end
    end

    // Transaction FSM: IDLE grants, ACCESS strobes the slave, RESP acks the owner
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.tb_we   <= 1'b0;
            bus.tb_oe   <= 1'b0;
            bus.spr_we  <= 1'b0;
            bus.spr_oe  <= 1'b0;
            bus.m0_ack  <= 1'b0;
            bus.m1_ack  <= 1'b0;
            bus.busy    <= 1'b0;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            we_q        <= 1'b0;
            sel_tb      <= 1'b0;
            sel_spr     <= 1'b0;
            hold0       <= '0;
            hold1       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any_c) begin
                        owner         <= win_c;
                        last_grant    <= win_c;
                        bus.bus_addr  <= win_addr_c;
                        bus.bus_wdata <= win_wdata_c;
                        we_q          <= win_we_c;
                        sel_tb        <= win_tb_c;
                        sel_spr       <= win_spr_c;
                        bus.tb_we     <= win_tb_c  &  win_we_c;
                        bus.tb_oe     <= win_tb_c  & ~win_we_c;
                        bus.spr_we    <= win_spr_c &  win_we_c;
                        bus.spr_oe    <= win_spr_c & ~win_we_c;
                        bus.busy      <= 1'b1;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus.tb_we  <= 1'b0;
                    bus.tb_oe  <= 1'b0;
                    bus.spr_we <= 1'b0;
                    bus.spr_oe <= 1'b0;
                    bus.m0_ack <= ~owner;
                    bus.m1_ack <= owner;
                    state      <= RESP;
                end
                RESP: begin
                    bus.m0_ack <= 1'b0;
                    bus.m1_ack <= 1'b0;
                    bus.busy   <= 1'b0;
                    if (owner) begin
                        hold1 <= resp_data_c;
                    end else begin
                        hold0 <= resp_data_c;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vectors, corner sequences and random traffic vs a grant-level model.
module tb_bus_arbiter;
    localparam int unsigned VB = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic cont  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bus_arbiter_if bi();
    bus_arbiter_if bz();

    bus_arbiter #(.VBLANK_CYCLES(VB), .TB_PAGE(4'h4), .SPR_PAGE(4'h5)) dut (
        .clk(clk), .reset(reset), .bus(bi));
    bus_arbiter #(.VBLANK_CYCLES(0), .TB_PAGE(4'h4), .SPR_PAGE(4'h5)) dut_nowin (
        .clk(clk), .reset(reset), .bus(bz));

    // Second instance: both masters request together whenever cont is set
    assign bz.vsync     = bi.vsync;
    assign bz.m0_req    = cont;
    assign bz.m1_req    = cont;
    assign bz.m0_addr   = 12'h401;
    assign bz.m1_addr   = 12'h502;
    assign bz.m0_we     = 1'b0;
    assign bz.m1_we     = 1'b0;
    assign bz.m0_wdata  = 8'h00;
    assign bz.m1_wdata  = 8'h00;
    assign bz.tb_rdata  = 8'h00;
    assign bz.spr_rdata = 8'h00;

    function automatic logic [7:0] f_tb(input logic [11:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] f_spr(input logic [11:0] a);
        return a[7:0] + 8'h39;
    endfunction

    // Slave models: registered read, one cycle latency
    always @(posedge clk) begin
        if (reset) begin
            bi.tb_rdata  <= 8'h00;
            bi.spr_rdata <= 8'h00;
        end else begin
            if (bi.tb_oe)  bi.tb_rdata  <= f_tb(bi.bus_addr);
            if (bi.spr_oe) bi.spr_rdata <= f_spr(bi.bus_addr);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: cycle numbers of grants, window derived from the last vsync edge time
    int   cyc = 0, next_free = 0, last_g = 1, own = 0, edge_cyc = 0;
    int   acc_cyc = -10, resp_cyc = -10;
    bit   prev_vs = 1'b1, have_edge = 1'b0;
    logic [11:0] x_addr = '0;
    logic [7:0]  x_wd = '0, x_rdata = '0;
    logic [3:0]  x_strb = '0;
    logic [7:0]  hold_m [2];

    always @(posedge clk) begin : model
        int  w;
        bit  win;
        logic [3:0] pg;
        cyc = cyc + 1;
        if (reset) begin
            next_free = cyc + 1;
            last_g    = 1;
            prev_vs   = 1'b1;
            have_edge = 1'b0;
            acc_cyc   = -10;
            resp_cyc  = -10;
            hold_m[0] = 8'h00;
            hold_m[1] = 8'h00;
        end else begin
            if (cyc == resp_cyc + 1) hold_m[own] = x_rdata;
            if (cyc >= next_free && (bi.m0_req || bi.m1_req)) begin
                win = have_edge && (cyc - edge_cyc >= 1) && (cyc - edge_cyc <= int'(VB));
                if (win && bi.m1_req)              w = 1;
                else if (bi.m0_req && !bi.m1_req)  w = 0;
                else if (bi.m1_req && !bi.m0_req)  w = 1;
                else                               w = 1 - last_g;
                last_g    = w;
                own       = w;
                next_free = cyc + 3;
                acc_cyc   = cyc;
                resp_cyc  = cyc + 1;
                x_addr    = (w == 1) ? bi.m1_addr  : bi.m0_addr;
                x_wd      = (w == 1) ? bi.m1_wdata : bi.m0_wdata;
                pg        = x_addr[11:8];
                if ((w == 1) ? bi.m1_we : bi.m0_we) begin
                    x_strb  = {pg == 4'h4, 1'b0, pg == 4'h5, 1'b0};
                    x_rdata = 8'h00;
                end else begin
                    x_strb  = {1'b0, pg == 4'h4, 1'b0, pg == 4'h5};
                    x_rdata = (pg == 4'h4) ? f_tb(x_addr) : (pg == 4'h5) ? f_spr(x_addr) : 8'hFF;
                end
            end
            if (bi.vsync && !prev_vs) begin
                have_edge = 1'b1;
                edge_cyc  = cyc;
            end
            prev_vs = bi.vsync;
        end
    end

    // Model comparison every cycle, away from the active edge
    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("model strobes", {bi.tb_we, bi.tb_oe, bi.spr_we, bi.spr_oe},
                (cyc == acc_cyc) ? x_strb : 4'h0);
            chk("model acks", {bi.m1_ack, bi.m0_ack},
                (cyc == resp_cyc) ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00);
            chk("model busy", bi.busy, (cyc == acc_cyc) || (cyc == resp_cyc));
            chk("model m0_rdata", bi.m0_rdata, (cyc == resp_cyc && own == 0) ? x_rdata : hold_m[0]);
            chk("model m1_rdata", bi.m1_rdata, (cyc == resp_cyc && own == 1) ? x_rdata : hold_m[1]);
            if (cyc == acc_cyc) begin
                chk("model bus_addr", bi.bus_addr, x_addr);
                chk("model bus_wdata", bi.bus_wdata, x_wd);
            end
        end
    end

    task automatic set_m(input int m, input logic r, input logic [11:0] a, input logic w, input logic [7:0] d);
        if (m == 0) begin
            bi.m0_req = r; bi.m0_addr = a; bi.m0_we = w; bi.m0_wdata = d;
        end else begin
            bi.m1_req = r; bi.m1_addr = a; bi.m1_we = w; bi.m1_wdata = d;
        end
    endtask

    task automatic set_req(input int m, input logic r);
        if (m == 0) bi.m0_req = r;
        else        bi.m1_req = r;
    endtask

    function automatic logic [11:0] rnd_addr();
        logic [3:0] pg;
        case ($urandom_range(0, 3))
            0:       pg = 4'h4;
            1:       pg = 4'h5;
            2:       pg = 4'($urandom_range(0, 15));
            default: pg = 4'h5;
        endcase
        return {pg, 8'($urandom_range(0, 255))};
    endfunction

    typedef struct {
        int          m;
        logic [11:0] a;
        logic        we;
        logic [7:0]  wd;
        logic [3:0]  strb;   // {tb_we, tb_oe, spr_we, spr_oe}
        logic [7:0]  rd;
    } vec_t;

    // One isolated transaction; entered and left at a negedge with the arbiter idle
    task automatic run_vec(input vec_t v, input int idx);
        logic [3:0]  s_or;
        int          s_cnt;
        logic [11:0] ba;
        int          ack_k;
        logic [7:0]  rd;
        logic        other;
        logic [3:0]  s;
        s_or = '0; s_cnt = 0; ba = '0; ack_k = -1; rd = '0; other = 1'b0;
        set_m(v.m, 1'b1, v.a, v.we, v.wd);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            s = {bi.tb_we, bi.tb_oe, bi.spr_we, bi.spr_oe};
            if (s != 4'h0) begin
                s_cnt++;
                s_or |= s;
                ba = bi.bus_addr;
            end
            if ((v.m == 0) ? bi.m1_ack : bi.m0_ack) other = 1'b1;
            if ((v.m == 0) ? bi.m0_ack : bi.m1_ack) begin
                ack_k = k;
                rd = (v.m == 0) ? bi.m0_rdata : bi.m1_rdata;
                break;
            end
        end
        set_req(v.m, 1'b0);
        chk($sformatf("vec%0d strobes", idx), s_or, v.strb);
        chk($sformatf("vec%0d strobe cycles", idx), s_cnt, (v.strb != 4'h0) ? 1 : 0);
        if (v.strb != 4'h0) chk($sformatf("vec%0d bus_addr", idx), ba, v.a);
        chk($sformatf("vec%0d ack latency", idx), ack_k, 2);
        chk($sformatf("vec%0d rdata", idx), rd, v.rd);
        chk($sformatf("vec%0d other ack", idx), other, 1'b0);
        @(negedge clk);
        chk($sformatf("vec%0d rdata hold", idx), (v.m == 0) ? bi.m0_rdata : bi.m1_rdata, v.rd);
    endtask

    initial begin
        vec_t vt [8];
        int   q_m[$], q_j[$], q_z[$];
        int   exp_v [7];
        int   exp_z [7];
        int   exp_s [9];
        int   nack;
        vt[0] = '{0, 12'h412, 1'b1, 8'hA5, 4'b1000, 8'h00};
        vt[1] = '{1, 12'h503, 1'b0, 8'h00, 4'b0001, 8'h3C};
        vt[2] = '{1, 12'h7FF, 1'b0, 8'h00, 4'b0000, 8'hFF};
        vt[3] = '{0, 12'h4A0, 1'b0, 8'h00, 4'b0100, 8'hFA};
        vt[4] = '{1, 12'h5FF, 1'b1, 8'h77, 4'b0010, 8'h00};
        vt[5] = '{0, 12'h000, 1'b1, 8'h12, 4'b0000, 8'h00};
        vt[6] = '{0, 12'h510, 1'b0, 8'h00, 4'b0001, 8'h49};
        vt[7] = '{1, 12'h42C, 1'b0, 8'h00, 4'b0100, 8'h76};
        exp_v = '{0, 1, 1, 1, 1, 0, 1};
        exp_z = '{0, 1, 0, 1, 0, 1, 0};
        exp_s = '{0, 1, 0, 1, 0, 1, 1, 1, 0};

        bi.vsync = 1'b0;
        set_m(0, 1'b0, 12'h000, 1'b0, 8'h00);
        set_m(1, 1'b0, 12'h000, 1'b0, 8'h00);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset ctl", {bi.m1_ack, bi.m0_ack, bi.tb_we, bi.tb_oe, bi.spr_we, bi.spr_oe, bi.busy}, 7'h0);
        chk("reset data", {bi.bus_addr, bi.bus_wdata, bi.m0_rdata, bi.m1_rdata}, 36'h0);
        reset = 1'b0;
        @(negedge clk);

        // Directed single transactions
        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Continuous requests from reset: alternation, 3-cycle spacing
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_m(0, 1'b1, 12'h401, 1'b0, 8'h00);
        set_m(1, 1'b1, 12'h502, 1'b1, 8'h5E);
        q_m.delete(); q_j.delete();
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            if (bi.m0_ack) begin q_m.push_back(0); q_j.push_back(j); end
            if (bi.m1_ack) begin q_m.push_back(1); q_j.push_back(j); end
        end
        set_req(0, 1'b0); set_req(1, 1'b0);
        chk("alt ack count", q_m.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_m.size()) begin
                chk($sformatf("alt grant%0d", i), q_m[i], i % 2);
                chk($sformatf("alt ack cycle%0d", i), q_j[i], 2 + 3 * i);
            end
        end
        repeat (2) @(negedge clk);

        // Vblank window (8 cycles) vs window-disabled instance
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_req(0, 1'b1); set_req(1, 1'b1);
        cont = 1'b1;
        q_m.delete(); q_z.delete();
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (j == 4)  bi.vsync = 1'b1;
            if (j == 14) bi.vsync = 1'b0;
            if (bi.m0_ack) q_m.push_back(0);
            if (bi.m1_ack) q_m.push_back(1);
            if (bz.m0_ack) q_z.push_back(0);
            if (bz.m1_ack) q_z.push_back(1);
        end
        set_req(0, 1'b0); set_req(1, 1'b0);
        cont = 1'b0;
        chk("vb ack count", q_m.size(), 7);
        chk("nowin ack count", q_z.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < q_m.size()) chk($sformatf("vb grant%0d", i), q_m[i], exp_v[i]);
            if (i < q_z.size()) chk($sformatf("nowin grant%0d", i), q_z[i], exp_z[i]);
        end
        repeat (2) @(negedge clk);

        // Reset during ACCESS of an m0 write
        set_m(0, 1'b1, 12'h420, 1'b1, 8'h11);
        @(negedge clk);
        chk("abort access strobe", bi.tb_we, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort after reset", {bi.m1_ack, bi.m0_ack, bi.tb_we, bi.tb_oe, bi.spr_we, bi.spr_oe, bi.busy}, 7'h0);
        reset = 1'b0;
        set_req(0, 1'b0);
        nack = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (bi.m0_ack || bi.m1_ack) nack++;
        end
        chk("abort no ack", nack, 0);
        set_req(0, 1'b1); set_req(1, 1'b1);
        q_m.delete();
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (bi.m0_ack) q_m.push_back(0);
            if (bi.m1_ack) q_m.push_back(1);
        end
        set_req(0, 1'b0); set_req(1, 1'b0);
        chk("abort tie count", q_m.size(), 2);
        if (q_m.size() > 0) chk("abort first tie", q_m[0], 0);
        repeat (2) @(negedge clk);

        // vsync high through reset release, then a real edge later
        reset = 1'b1;
        bi.vsync = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        set_req(0, 1'b1); set_req(1, 1'b1);
        q_m.delete();
        for (int j = 1; j <= 26; j++) begin
            @(negedge clk);
            if (j == 12) bi.vsync = 1'b0;
            if (j == 13) bi.vsync = 1'b1;
            if (bi.m0_ack) q_m.push_back(0);
            if (bi.m1_ack) q_m.push_back(1);
        end
        set_req(0, 1'b0); set_req(1, 1'b0);
        bi.vsync = 1'b0;
        chk("vshigh ack count", q_m.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < q_m.size()) chk($sformatf("vshigh grant%0d", i), q_m[i], exp_s[i]);
        end
        repeat (2) @(negedge clk);

        // Random traffic, checked by the reference model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if ((m == 0) ? bi.m0_ack : bi.m1_ack) begin
                    set_m(m, 1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
                end else if (!((m == 0) ? bi.m0_req : bi.m1_req) && $urandom_range(0, 3) == 0) begin
                    set_m(m, 1'b1, rnd_addr(), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
                end
            end
            if ($urandom_range(0, 29) == 0) bi.vsync = ~bi.vsync;
        end
        set_req(0, 1'b0); set_req(1, 1'b0);
        bi.vsync = 1'b0;
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
